// File: rtl/stopwatch_buttons.sv
// Button front end for the stopwatch timer: sync, debounce, edge-detect.
// Clear beats start/stop; also shadows the timer run state.
module stopwatch_buttons #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_startstop,
    input  logic btn_clear,
    output logic toggle,
    output logic sw_reset,
    output logic running,
    output logic clear_held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam int SS  = 0;
    localparam int CLR = 1;

    logic [1:0]    raw;
    logic [1:0]    s1_q;
    logic [1:0]    s2_q;
    logic [1:0]    stable_q;
    logic [1:0]    stable_d;
    logic [1:0]    rise;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          toggle_q;
    logic          toggle_d;
    logic          sw_reset_q;
    logic          sw_reset_d;
    logic          running_q;
    logic          running_d;
    logic          clear_held_q;

    assign raw = {btn_clear, btn_startstop};

    // Debounce: accept a level only after it differs from stable for D edges
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    assign rise = stable_d & ~stable_q;

    // Arbitrate pulses; a held clear also blocks toggles
    always_comb begin
        sw_reset_d = rise[CLR];
        toggle_d   = rise[SS] & ~stable_d[CLR];
        running_d  = running_q;
        if (sw_reset_q) begin
            running_d = 1'b0;
        end else if (toggle_q) begin
            running_d = ~running_q;
        end
    end

    // Register all state; reset is synchronous
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            cnt_q        <= '{default: '0};
            toggle_q     <= 1'b0;
            sw_reset_q   <= 1'b0;
            running_q    <= 1'b0;
            clear_held_q <= 1'b0;
        end else begin
            s1_q         <= raw;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            toggle_q     <= toggle_d;
            sw_reset_q   <= sw_reset_d;
            running_q    <= running_d;
            clear_held_q <= stable_d[CLR];
        end
    end

    assign toggle     = toggle_q;
    assign sw_reset   = sw_reset_q;
    assign running    = running_q;
    assign clear_held = clear_held_q;

endmodule

// File: tb/tb_stopwatch_buttons.sv
// Bench for stopwatch_buttons: per-cycle scoreboard against a
// history-window model, plus directed latency and pulse-count checks.
module tb_stopwatch_buttons;

    localparam int D = 4;

    logic clk;
    logic reset;
    logic btn_startstop;
    logic btn_clear;
    logic toggle;
    logic sw_reset;
    logic running;
    logic clear_held;

    stopwatch_buttons #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_startstop(btn_startstop),
        .btn_clear    (btn_clear),
        .toggle       (toggle),
        .sw_reset     (sw_reset),
        .running      (running),
        .clear_held   (clear_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;
    int ecount;
    int tog_cnt;
    int sw_cnt;
    int last_tog;
    int last_sw;
    int e0;
    logic prev_tog;
    logic prev_sw;
    logic [3:0] exp_q[$];

    // model state
    logic [1:0]   m_s1;
    logic [1:0]   m_s2;
    logic [1:0]   m_st;
    logic [D-1:0] m_hist [2];
    logic         m_tog;
    logic         m_sw;
    logic         m_run;
    logic         m_ch;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     tag, got, exp, ecount);
        end
    endtask

    // A level is accepted once the last D synchronised samples
    // all disagree with the accepted level.
    task automatic model_edge(input logic ss, input logic cl, input logic rs,
                              output logic [3:0] e);
        logic [1:0] nst;
        logic [1:0] rise;
        logic       nrun;
        if (rs) begin
            m_s1 = '0; m_s2 = '0; m_st = '0;
            m_hist[0] = '0; m_hist[1] = '0;
            m_tog = 0; m_sw = 0; m_run = 0; m_ch = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_hist[i] = {m_hist[i][D-2:0], m_s2[i]};
                nst[i] = (m_hist[i] == {D{~m_st[i]}}) ? ~m_st[i] : m_st[i];
            end
            rise  = nst & ~m_st;
            nrun  = m_sw ? 1'b0 : (m_tog ? ~m_run : m_run);
            m_tog = rise[0] & ~nst[1];
            m_sw  = rise[1];
            m_run = nrun;
            m_ch  = nst[1];
            m_st  = nst;
            m_s2  = m_s1;
            m_s1  = {cl, ss};
        end
        e = {m_tog, m_sw, m_run, m_ch};
    endtask

    // Called at negedge: drive, predict, clock, compare
    task automatic step(input logic ss, input logic cl, input logic rs);
        logic [3:0] e;
        logic [3:0] got;
        btn_startstop = ss;
        btn_clear     = cl;
        reset         = rs;
        model_edge(ss, cl, rs, e);
        exp_q.push_back(e);
        @(posedge clk);
        ecount++;
        #1;
        got = {toggle, sw_reset, running, clear_held};
        e = exp_q.pop_front();
        chk("outputs", got, e);
        if (toggle & sw_reset) chk("tog_sw_excl", 1, 0);
        if (toggle & prev_tog) chk("tog_double", 1, 0);
        if (sw_reset & prev_sw) chk("sw_double", 1, 0);
        prev_tog = toggle;
        prev_sw  = sw_reset;
        if (toggle) begin tog_cnt++; last_tog = ecount; end
        if (sw_reset) begin sw_cnt++; last_sw = ecount; end
        @(negedge clk);
    endtask

    task automatic hold(input logic ss, input logic cl, input int n);
        for (int k = 0; k < n; k++) step(ss, cl, 1'b0);
    endtask

    task automatic clr_counts();
        tog_cnt = 0; sw_cnt = 0; last_tog = -1; last_sw = -1;
    endtask

    initial begin
        n_vec = 0; n_bad = 0; ecount = 0;
        prev_tog = 0; prev_sw = 0;
        m_s1 = '0; m_s2 = '0; m_st = '0;
        m_hist[0] = '0; m_hist[1] = '0;
        m_tog = 0; m_sw = 0; m_run = 0; m_ch = 0;
        reset = 1'b1; btn_startstop = 1'b0; btn_clear = 1'b0;
        clr_counts();
        @(negedge clk);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("reset_outs", {toggle, sw_reset, running, clear_held}, 4'b0000);
        hold(0, 0, 3);

        // clean press
        clr_counts();
        e0 = ecount + 1;
        hold(1, 0, 20);
        chk("clean_tog_cnt", tog_cnt, 1);
        chk("clean_tog_edge", last_tog, e0 + 5);
        chk("clean_sw_cnt", sw_cnt, 0);
        chk("clean_running", running, 1);
        hold(0, 0, 10);
        chk("release_tog_cnt", tog_cnt, 1);

        // bounce reject then a real press
        clr_counts();
        for (int i = 0; i < 40; i++) step((i % 8) != 3 && (i % 8) != 7, 0, 0);
        chk("bounce_tog_cnt", tog_cnt, 0);
        hold(1, 0, 10);
        chk("bounce_then_hold", tog_cnt, 1);
        chk("bounce_running", running, 0);
        hold(0, 0, 10);

        // two presses
        clr_counts();
        hold(1, 0, 10);
        chk("two_run_a", running, 1);
        hold(0, 0, 10);
        hold(1, 0, 10);
        chk("two_run_b", running, 0);
        hold(0, 0, 10);
        chk("two_tog_cnt", tog_cnt, 2);

        // simultaneous press
        clr_counts();
        e0 = ecount + 1;
        hold(1, 1, 15);
        chk("sim_sw_cnt", sw_cnt, 1);
        chk("sim_sw_edge", last_sw, e0 + 5);
        chk("sim_tog_cnt", tog_cnt, 0);
        chk("sim_running", running, 0);
        chk("sim_clear_held", clear_held, 1);
        hold(0, 0, 10);
        chk("sim_clear_rel", clear_held, 0);

        // clear while running, then start/stop under held clear
        clr_counts();
        hold(1, 0, 10);
        hold(0, 0, 10);
        chk("cwr_running", running, 1);
        hold(0, 1, 15);
        chk("cwr_sw_cnt", sw_cnt, 1);
        chk("cwr_run_off", running, 0);
        hold(1, 1, 10);
        hold(0, 1, 10);
        chk("cwr_tog_cnt", tog_cnt, 1);
        hold(0, 0, 10);

        // reset mid-press
        clr_counts();
        e0 = ecount + 1;
        hold(1, 0, 3);
        step(1, 0, 1);
        chk("rst_mid_outs", {toggle, sw_reset, running, clear_held}, 4'b0000);
        hold(1, 0, 15);
        chk("rst_tog_cnt", tog_cnt, 1);
        chk("rst_tog_edge", last_tog, e0 + 9);
        hold(0, 0, 10);

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_buttons.md
# stopwatch_buttons

Button-conditioning front end for the stopwatch timer. Synchronises and debounces two raw push-buttons (start/stop and clear) and converts each clean press into a single-cycle pulse. Outputs drive the timer stage directly: `toggle` feeds its toggle input and `sw_reset` feeds its reset input. The block guarantees the timer's precondition that toggle and reset are never high in the same cycle, and keeps a shadow copy of the run state.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronised samples a button must hold a new level before it is accepted. Legal range ≥ 1.
- `clk`  input  1  clock; all state on rising edge.
- `reset`  input  1  reset, synchronous, active-high.
- `btn_startstop`  input  1  raw start/stop button, asynchronous, active-high.
- `btn_clear`  input  1  raw clear button, asynchronous, active-high.
- `toggle`  output  1  one-cycle pulse per accepted start/stop press, to timer.
- `sw_reset`  output  1  one-cycle pulse per accepted clear press, to timer.
- `running`  output  1  shadow of timer run state.
- `clear_held`  output  1  debounced level of the clear button.

## Operation
- Per button: 2-flop synchroniser `s1`→`s2`, then debouncer holding `stable` plus counter `cnt`. `cnt` width is $clog2(DEBOUNCE_CYCLES+1).
- Debouncer, on each edge:
  - If `s2 == stable`: `cnt` ← 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable` ← `s2`, `cnt` ← 0.
  - Else: `cnt` ← `cnt+1`.
- Accept event: `stable` transitions 0→1. A 1→0 transition (release) produces no pulse.
- Raw pulses of fewer than DEBOUNCE_CYCLES synchronised cycles are rejected. Bounces reset `cnt` and never reach `stable`.
- Arbitration, all outputs registered:
  - `sw_reset` = clear accept event.
  - `toggle` = start/stop accept event AND NOT clear accept event AND NOT clear `stable`.
  - Clear has priority. A suppressed toggle is dropped, not deferred.
- `running`:
  - ← 0 on the `sw_reset` pulse edge.
  - Else ← `~running` on the `toggle` pulse edge.
  - Else holds.
- `clear_held` = clear `stable`, registered.
- Holding start/stop indefinitely yields exactly one `toggle`. A further toggle requires release to be accepted (`stable` back to 0), then a new press.

## Timing
- Reset (synchronous, at the edge where `reset` is sampled high): all sync flops, `stable`, `cnt`, `toggle`, `sw_reset`, `running`, `clear_held` ← 0.
- Reset mid-debounce discards progress. A button still held after reset deasserts is re-debounced from zero and produces one pulse.
- Latency: raw first sampled high at edge 0 and held → `s2` high after edge 1 → `stable` set at edge DEBOUNCE_CYCLES+1 → pulse high for exactly the cycle following edge DEBOUNCE_CYCLES+1. This is D+2 edges from first sample.
- Release latency is identical, with no output pulse. `clear_held` falls in the cycle after edge D+1 of the release.
- `toggle` and `sw_reset` are never both 1 in any cycle. Each is never high for two consecutive cycles.
- `running` reflects a pulse one cycle later. It updates on the same edge that ends the pulse cycle.
- DEBOUNCE_CYCLES = 1: a press is accepted on the first `s2` mismatch, giving a pulse after edge 2.

## Test plan
(DEBOUNCE_CYCLES = 4 unless stated.)
- Clean press: `btn_startstop` high from edge 0 for 20 cycles → `toggle` = 1 only in the cycle after edge 5; `running` 0→1 after edge 6; `sw_reset` stays 0.
- Bounce reject: `btn_startstop` pattern 1,1,1,0,1,1,1,0 repeated for 40 cycles → no `toggle`. Then held high 10 cycles → exactly one `toggle`.
- Two presses: press for 10 cycles, release for 10, press for 10 → two `toggle` pulses; `running` sequence 0→1→0.
- Simultaneous: both buttons rise on the same edge and are held → `sw_reset` pulse after edge 5, `toggle` never pulses, `running` = 0, `clear_held` = 1 from the cycle after edge 5.
- Clear while running: with `running` = 1, press `btn_clear` → one `sw_reset` pulse and `running` ← 0. A start/stop press while clear is held → no `toggle`.
- Reset mid-operation: `reset` asserted at edge 3 of a press that stays held → all outputs 0 at the next edge. After `reset` deasserts, one `toggle` pulse arrives D+2 edges later.
